// File: rtl/mul_seq_arbiter_if.sv
// Handshake bundle for mul_seq_arbiter: two operand requesters, one result channel and busy.
// The master modport is the requester/consumer side; the slave modport is the multiplier.
interface mul_seq_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ovf;
    logic             rsp_id;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_ovf, rsp_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_ovf, rsp_id, busy
    );
endinterface

// File: rtl/mul_seq_arbiter.sv
// Shared shift-add multiplier with a two-way round-robin front end; returns (a*b) mod 2^WIDTH and overflow.
// Define MUL_SEQ_ARBITER_FORMAL_EN to add a shadow product register and formal properties.
module mul_seq_arbiter #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    mul_seq_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic               r_last_grant;
    logic [2*WIDTH-1:0] r_a_sh;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b_sh;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_id;

    logic               w_idle;
    logic               w_done;
    logic               w_grant;
    logic               w_any_valid;
    logic               w_hs;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;

    always_comb begin
        w_idle      = (r_state == S_IDLE);
        w_done      = (r_state == S_DONE);
        w_any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = bus.req1_valid;
        end
        w_hs = w_idle & w_any_valid;
        w_a  = w_grant ? bus.req1_a : bus.req0_a;
        w_b  = w_grant ? bus.req1_b : bus.req0_b;
    end

    assign bus.req0_ready = w_idle & w_any_valid & ~w_grant;
    assign bus.req1_ready = w_idle & w_any_valid & w_grant;
    assign bus.busy       = ~w_idle;
    assign bus.rsp_valid  = w_done;
    assign bus.rsp_data   = w_done ? r_acc[WIDTH-1:0] : '0;
    assign bus.rsp_ovf    = w_done & (|r_acc[2*WIDTH-1:WIDTH]);
    assign bus.rsp_id     = w_done & r_id;

    // RUN spans WIDTH+1 cycles; the final step sees b_sh already empty, so it adds nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_a_sh       <= '0;
            r_acc        <= '0;
            r_b_sh       <= '0;
            r_cnt        <= '0;
            r_id         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_a_sh       <= {{WIDTH{1'b0}}, w_a};
                        r_b_sh       <= w_b;
                        r_acc        <= '0;
                        r_cnt        <= '0;
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_b_sh[0]) begin
                        r_acc <= r_acc + r_a_sh;
                    end
                    r_a_sh <= r_a_sh << 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MUL_SEQ_ARBITER_FORMAL_EN
    logic [2*WIDTH-1:0] r_shadow;
    logic [1:0]         r_skip0;
    logic [1:0]         r_skip1;

    // Skip counters track grants handed to the other side while a requester waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_skip0  <= '0;
            r_skip1  <= '0;
        end else begin
            if (w_hs) begin
                r_shadow <= {{WIDTH{1'b0}}, w_a} * {{WIDTH{1'b0}}, w_b};
            end
            if (!bus.req0_valid || bus.req0_ready) begin
                r_skip0 <= '0;
            end else if (bus.req1_ready && r_skip0 != 2'd3) begin
                r_skip0 <= r_skip0 + 2'd1;
            end
            if (!bus.req1_valid || bus.req1_ready) begin
                r_skip1 <= '0;
            end else if (bus.req0_ready && r_skip1 != 2'd3) begin
                r_skip1 <= r_skip1 + 2'd1;
            end
        end
    end

    a_result: assert property (@(posedge clk) disable iff (rst)
        bus.rsp_valid |-> (bus.rsp_data == r_shadow[WIDTH-1:0]) &&
                          (bus.rsp_ovf == (|r_shadow[2*WIDTH-1:WIDTH])));
    a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
        bus.rsp_valid && !bus.rsp_ready |=> bus.rsp_valid && $stable(bus.rsp_data) &&
                                            $stable(bus.rsp_ovf) && $stable(bus.rsp_id));
    a_one_ready: assert property (@(posedge clk) disable iff (rst)
        !(bus.req0_ready && bus.req1_ready));
    a_busy: assert property (@(posedge clk) disable iff (rst)
        bus.busy == (r_state != S_IDLE));
    a_fair0: assert property (@(posedge clk) disable iff (rst) r_skip0 <= 2'd1);
    a_fair1: assert property (@(posedge clk) disable iff (rst) r_skip1 <= 2'd1);

    m_req0_hold: assume property (@(posedge clk) disable iff (rst)
        bus.req0_valid && !bus.req0_ready |=> bus.req0_valid &&
                                              $stable(bus.req0_a) && $stable(bus.req0_b));
    m_req1_hold: assume property (@(posedge clk) disable iff (rst)
        bus.req1_valid && !bus.req1_ready |=> bus.req1_valid &&
                                              $stable(bus.req1_a) && $stable(bus.req1_b));
`endif
endmodule

// File: tb/tb_mul_seq_arbiter.sv
// Self-checking bench for mul_seq_arbiter: vector table, scoreboard of results, and
// hand-written sequences for arbitration, back-pressure and mid-operation reset.
module tb_mul_seq_arbiter;
   localparam int WIDTH = 8;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       id;
      logic [7:0] expData;
      logic       expOvf;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       ovf;
      logic       id;
   } rsp_t;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad = 0;
   rsp_t sbQ[$];
   int   grantLog[$];
   vec_t vecs[8];
   rsp_t monExp;

   mul_seq_arbiter_if #(.WIDTH(WIDTH)) bus ();

   mul_seq_arbiter #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one value and keep the running counters
   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference product, independent of how the DUT computes it
   function automatic rsp_t model(input logic [7:0] a, input logic [7:0] b, input logic id);
      logic [15:0] p;
      rsp_t r;
      p = 16'(a) * 16'(b);
      r.data = p[7:0];
      r.ovf  = |p[15:8];
      r.id   = id;
      return r;
   endfunction

   // Pulse reset aligned just after a rising edge
   task automatic pulseReset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Wait (bounded) until every pushed expectation has been consumed
   task automatic drainScoreboard();
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("sb_drain", sbQ.size(), 0);
   endtask

   // Issue one table request with rsp_ready high, then check latency and response
   task automatic applyStimulus(input vec_t v);
      int n;
      int lat;
      @(posedge clk); #1;
      if (v.id) begin
         bus.req1_valid = 1'b1; bus.req1_a = v.a; bus.req1_b = v.b;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_a = v.a; bus.req0_b = v.b;
      end
      n = 0;
      @(negedge clk);
      while (!(v.id ? bus.req1_ready : bus.req0_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("grant_in_time", int'(n < 50), 1);
      if (n < 50) sbQ.push_back(model(v.a, v.b, v.id));
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_a = 8'($urandom);
      bus.req0_b = 8'($urandom);
      bus.req1_a = 8'($urandom);
      bus.req1_b = 8'($urandom);
      checkOutput("busy_in_run", int'(bus.busy), 1);
      lat = 0;
      while (!bus.rsp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("latency", lat, WIDTH + 1);
      checkOutput("rsp_data", int'(bus.rsp_data), int'(v.expData));
      checkOutput("rsp_ovf", int'(bus.rsp_ovf), int'(v.expOvf));
      checkOutput("rsp_id", int'(bus.rsp_id), int'(v.id));
      @(posedge clk); #1;
   endtask

   // Monitor: ready exclusivity, grant log and scoreboard pop on each response handshake
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("one_ready", int'(bus.req0_ready & bus.req1_ready), 0);
         if (bus.req0_ready && bus.req0_valid) grantLog.push_back(0);
         if (bus.req1_ready && bus.req1_valid) grantLog.push_back(1);
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sbQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_rsp: got data %0d, required no response", bus.rsp_data);
            end else begin
               monExp = sbQ.pop_front();
               checkOutput("sb_data", int'(bus.rsp_data), int'(monExp.data));
               checkOutput("sb_ovf", int'(bus.rsp_ovf), int'(monExp.ovf));
               checkOutput("sb_id", int'(bus.rsp_id), int'(monExp.id));
            end
         end
      end
   end

   // Watchdog so the run can never hang
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence
   initial begin
      int n;
      int hi;
      int expOrder[4];
      vec_t v;

      vecs[0] = '{8'd12,  8'd10,  1'b0, 8'd120,  1'b0};
      vecs[1] = '{8'd20,  8'd13,  1'b1, 8'd4,    1'b1};
      vecs[2] = '{8'd255, 8'd255, 1'b1, 8'd1,    1'b1};
      vecs[3] = '{8'd77,  8'd0,   1'b1, 8'd0,    1'b0};
      vecs[4] = '{8'd16,  8'd16,  1'b0, 8'd0,    1'b1};
      vecs[5] = '{8'd15,  8'd17,  1'b1, 8'd255,  1'b0};
      vecs[6] = '{8'd128, 8'd2,   1'b0, 8'd0,    1'b1};
      vecs[7] = '{8'd1,   8'd200, 1'b0, 8'd200,  1'b0};
      expOrder = '{0, 1, 0, 1};

      rst = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
      bus.rsp_ready  = 1'b1;
      #1;
      checkOutput("rst_rsp_valid", int'(bus.rsp_valid), 0);
      checkOutput("rst_rsp_data", int'(bus.rsp_data), 0);
      checkOutput("rst_rsp_ovf", int'(bus.rsp_ovf), 0);
      checkOutput("rst_rsp_id", int'(bus.rsp_id), 0);
      checkOutput("rst_busy", int'(bus.busy), 0);
      checkOutput("rst_ready0", int'(bus.req0_ready), 0);
      checkOutput("rst_ready1", int'(bus.req1_ready), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("idle_no_valid_ready0", int'(bus.req0_ready), 0);

      $display("[TB] vector table");
      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
      drainScoreboard();

      $display("[TB] round-robin with both requesters valid");
      pulseReset();
      grantLog.delete();
      sbQ.push_back(model(8'd2, 8'd3, 1'b0));
      sbQ.push_back(model(8'd4, 8'd5, 1'b1));
      sbQ.push_back(model(8'd2, 8'd3, 1'b0));
      sbQ.push_back(model(8'd4, 8'd5, 1'b1));
      bus.req0_valid = 1'b1; bus.req0_a = 8'd2; bus.req0_b = 8'd3;
      bus.req1_valid = 1'b1; bus.req1_a = 8'd4; bus.req1_b = 8'd5;
      n = 0;
      while (grantLog.size() < 4 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      checkOutput("rr_grants_in_time", int'(n < 200), 1);
      for (int i = 0; i < 4; i++) begin
         checkOutput("rr_grant_order", (i < grantLog.size()) ? grantLog[i] : -1, expOrder[i]);
      end
      drainScoreboard();

      $display("[TB] back-pressure with requester 0 pending");
      bus.rsp_ready = 1'b0;
      @(posedge clk); #1;
      bus.req0_valid = 1'b1; bus.req0_a = 8'd9; bus.req0_b = 8'd7;
      n = 0;
      @(negedge clk);
      while (!bus.req0_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("bp_grant_in_time", int'(n < 50), 1);
      sbQ.push_back(model(8'd9, 8'd7, 1'b0));
      @(posedge clk); #1;
      bus.req0_a = 8'd6; bus.req0_b = 8'd7;
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("bp_latency", n, WIDTH + 1);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_valid_held", int'(bus.rsp_valid), 1);
         checkOutput("bp_data_held", int'(bus.rsp_data), 63);
         checkOutput("bp_ovf_held", int'(bus.rsp_ovf), 0);
         checkOutput("bp_id_held", int'(bus.rsp_id), 0);
         checkOutput("bp_no_grant", int'(bus.req0_ready), 0);
         checkOutput("bp_busy", int'(bus.busy), 1);
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      sbQ.push_back(model(8'd6, 8'd7, 1'b0));
      @(posedge clk); #1;
      checkOutput("bp_idle_after_hs", int'(bus.busy), 0);
      checkOutput("bp_regrant", int'(bus.req0_ready), 1);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      checkOutput("bp_busy_again", int'(bus.busy), 1);
      drainScoreboard();

      $display("[TB] reset in the middle of RUN");
      @(posedge clk); #1;
      bus.req0_valid = 1'b1; bus.req0_a = 8'd200; bus.req0_b = 8'd100;
      n = 0;
      @(negedge clk);
      while (!bus.req0_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("mr_grant_in_time", int'(n < 50), 1);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("mr_rsp_valid", int'(bus.rsp_valid), 0);
      checkOutput("mr_rsp_data", int'(bus.rsp_data), 0);
      checkOutput("mr_rsp_ovf", int'(bus.rsp_ovf), 0);
      checkOutput("mr_rsp_id", int'(bus.rsp_id), 0);
      checkOutput("mr_busy", int'(bus.busy), 0);
      checkOutput("mr_ready0", int'(bus.req0_ready), 0);
      checkOutput("mr_ready1", int'(bus.req1_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      hi = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (bus.rsp_valid) hi++;
      end
      checkOutput("mr_no_response", hi, 0);
      v = '{8'd3, 8'd5, 1'b0, 8'd15, 1'b0};
      applyStimulus(v);
      drainScoreboard();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
